seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 8, is the maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 10, is the match counter width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port x, input, 1: serial data bit, sampled every clock while ARMED.
REQ-006 Port cfg_valid, input, 1: one-cycle request to load a configuration.
REQ-007 Port cfg_pattern, input, MAX_LEN: pattern to detect; bit 0 is the last-arriving bit.
REQ-008 Port cfg_len, input, 4: pattern length, legal range 1..MAX_LEN.
REQ-009 Port cfg_overlap, input, 1: 1 allows overlapping matches, 0 does not.
REQ-010 Port cfg_target, input, CNT_W: match count at which to finish; 0 means run until stop.
REQ-011 Port cfg_ready, output, 1: high when a configuration can be accepted.
REQ-012 Port cfg_err, output, 1: one-cycle pulse when a cfg_valid is rejected.
REQ-013 Port start, input, 1: arms detection.
REQ-014 Port stop, input, 1: aborts detection.
REQ-015 Port y, output, 1: one-cycle match pulse.
REQ-016 Port count, output, CNT_W: number of matches since the last start.
REQ-017 Port busy, output, 1: high while ARMED.
REQ-018 Port done, output, 1: level, high in DONE.

Function
REQ-019 The FSM has three states: IDLE, ARMED and DONE.
REQ-020 cfg_ready = 1 in IDLE and DONE, and 0 in ARMED.
REQ-021 cfg_valid with cfg_ready=1 and 1<=cfg_len<=MAX_LEN loads pattern, len, overlap and target at that edge.
REQ-022 cfg_valid with an illegal cfg_len, or while ARMED, leaves the configuration unchanged and pulses cfg_err the next cycle.
REQ-023 start in IDLE or DONE -> ARMED; clears count, the history register and the bit counter; sampling begins at the next edge.
REQ-024 Same-cycle cfg_valid and start in IDLE/DONE: the configuration loads and start is ignored.
REQ-025 Same-cycle start and stop: stop wins, and the state is IDLE.
REQ-026 In ARMED, each edge shifts x into the history (hist <= {hist, x}) and increments the bit counter, saturating at len.
REQ-027 A match occurs at an edge where the bit counter after the shift is >= len and the low len bits of hist equal the low len bits of pattern.
REQ-028 y is registered: it is 1 in the cycle immediately after the edge that sampled the last pattern bit, with latency 1 cycle.
REQ-029 On a match with overlap=0, the bit counter clears to 0 so that the next match needs len new bits; with overlap=1 the bit counter is unchanged.
REQ-030 On a match, count increments at the same edge that sets y, saturating at 2^CNT_W-1 without wrapping.
REQ-031 If target != 0 and the post-increment count equals target, the FSM goes ARMED -> DONE at that edge, y still pulses, and no further sampling occurs.
REQ-032 stop in ARMED -> IDLE; count is retained and y is 0 from the next cycle.
REQ-033 stop in IDLE or DONE -> IDLE.
REQ-034 count holds its value in IDLE and DONE until the next start.
REQ-035 x is ignored outside ARMED, and y never asserts outside the cycle following an ARMED match.

Reset
REQ-036 rst asserted forces, asynchronously: state IDLE, y=0, count=0, busy=0, done=0, cfg_err=0, cfg_ready=1, hist=0, bit counter=0.
REQ-037 Reset configuration: pattern=3'b010 (zero-extended), len=3, overlap=1, target=0, so that start alone yields a 010 detector.
REQ-038 rst mid-ARMED discards any partial match, and no y pulse follows.

Structure
REQ-039 Package seq_det_pkg holds the state enum, MAX_LEN, CNT_W and the reset configuration constants.
REQ-040 Sub-module seq_match_core holds the history shift register, bit counter and masked compare; it outputs a combinational match and takes clear/enable inputs from the FSM.

Verification
REQ-041 Reset then start with the default config, x = 0,1,0,1,0 -> y pulses after the 3rd and 5th bits, count=2.
REQ-042 Configure pattern=0101, len=4, overlap=0, x = 0,1,0,1,0,1 -> exactly one y, after the 4th bit, count=1.
REQ-043 cfg_target=2 with the default pattern, stream 0100100 -> the 2nd y occurs, done=1 and busy=0 in the same cycle, and later bits are ignored.
REQ-044 cfg_valid with cfg_len=0, then cfg_valid during ARMED -> cfg_err pulses twice and the configuration is unchanged.
REQ-045 Assert stop, or assert rst, in the middle of a match (x=0,1 then the stop or rst edge) -> no y, state IDLE; count is retained after stop and 0 after rst.
REQ-046 CNT_W=2 override, 5 matches -> count saturates at 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
package seq_det_pkg;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned LEN_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Out of reset the block is a 3-bit "010" detector with overlap, no target.
    localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(3'b010);
    localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(3);
    localparam logic               RST_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_match_core.sv
// History shift register, saturating bit counter and length-masked pattern compare.
module seq_match_core #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               x,
    input  logic               overlap,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match_c
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]   bit_cnt_inc;

    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // Match is judged on the post-shift history, so it fires on the edge that samples the last bit.
    always_comb begin
        hist_nxt    = {hist[MAX_LEN-2:0], x};
        bit_cnt_inc = (bit_cnt >= len) ? len : bit_cnt + LEN_W'(1);
        match_c     = en && (bit_cnt_inc >= len) &&
                      ((hist_nxt & mask) == (pattern & mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist    <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            hist    <= '0;
            bit_cnt <= '0;
        end else if (en) begin
            hist    <= hist_nxt;
            bit_cnt <= (match_c && !overlap) ? '0 : bit_cnt_inc;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial sequence detector: IDLE/ARMED/DONE control around a match core.
module seq_detect_ctrl #(
    parameter int unsigned MAX_LEN = seq_det_pkg::MAX_LEN,
    parameter int unsigned CNT_W   = seq_det_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               cfg_valid,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    output logic               cfg_ready,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    output logic               y,
    output logic [CNT_W-1:0]   count,
    output logic               busy,
    output logic               done
);

    import seq_det_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   count_inc;
    logic               len_ok;
    logic               cfg_load;
    logic               cfg_rej;
    logic               arm;
    logic               sample;
    logic               match_c;

    assign len_ok    = (cfg_len != 4'd0) && (32'(cfg_len) <= MAX_LEN);
    assign count_inc = (count == '1) ? count : count + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // A cfg_valid in the same cycle as start takes priority; stop beats everything.
    always_comb begin
        state_nxt = state;
        cfg_load  = 1'b0;
        cfg_rej   = 1'b0;
        arm       = 1'b0;
        sample    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (cfg_valid) begin
                    cfg_load = len_ok;
                    cfg_rej  = !len_ok;
                end
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start && !cfg_valid) begin
                    state_nxt = ST_ARMED;
                    arm       = 1'b1;
                end
            end
            ST_ARMED: begin
                cfg_rej = cfg_valid;
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    sample = 1'b1;
                    if (match_c && (tgt_q != '0) && (count_inc == tgt_q))
                        state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q     <= MAX_LEN'(RST_PATTERN);
            len_q     <= RST_LEN;
            ovl_q     <= RST_OVERLAP;
            tgt_q     <= '0;
            count     <= '0;
            y         <= 1'b0;
            cfg_err   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            if (cfg_load) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
                tgt_q <= cfg_target;
            end
            if (arm)          count <= '0;
            else if (match_c) count <= count_inc;
            y         <= match_c;
            cfg_err   <= cfg_rej;
            busy      <= (state_nxt == ST_ARMED);
            done      <= (state_nxt == ST_DONE);
            cfg_ready <= (state_nxt != ST_ARMED);
        end
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (arm),
        .en      (sample),
        .x       (x),
        .overlap (ovl_q),
        .pattern (pat_q),
        .len     (len_q),
        .match_c (match_c)
    );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl, with a second CNT_W=2 instance for count saturation.
module tb_seq_detect_ctrl;

    logic       clk;
    logic       rst;
    logic       x;
    logic       cfg_valid;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [9:0] cfg_target;
    logic       start;
    logic       stop;

    logic       cfg_ready, cfg_err, y, busy, done;
    logic [9:0] count;
    logic       cfg_ready2, cfg_err2, y2, busy2, done2;
    logic [1:0] count2;

    int n_checks;
    int n_pass;

    seq_detect_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .cfg_valid   (cfg_valid),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .start       (start),
        .stop        (stop),
        .y           (y),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    seq_detect_ctrl #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .cfg_valid   (cfg_valid),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target[1:0]),
        .cfg_ready   (cfg_ready2),
        .cfg_err     (cfg_err2),
        .start       (start),
        .stop        (stop),
        .y           (y2),
        .count       (count2),
        .busy        (busy2),
        .done        (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic exp_y, input string tag);
        x = b;
        tick();
        check(tag, 32'(y), 32'(exp_y));
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                             input logic ovl, input logic [9:0] tgt);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_target  = tgt;
        tick();
        cfg_valid   = 1'b0;
    endtask

    initial begin
        logic [10:0] stream;
        logic [10:0] exp_ys;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; x = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; cfg_target = '0; start = 1'b0; stop = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_y", 32'(y), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Default 010 detector with overlap; also drives the CNT_W=2 instance past saturation
        start = 1'b1; tick(); start = 1'b0;
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_cfg_ready", 32'(cfg_ready), 32'd0);
        stream = 11'b01010101010;
        exp_ys = 11'b00101010101;
        for (int i = 10; i >= 0; i--) begin
            send(stream[i], exp_ys[i], $sformatf("dflt_y_bit%0d", 11 - i));
            if (i == 6) begin
                check("dflt_count_after5", 32'(count), 32'd2);
                check("sat_count_after5", 32'(count2), 32'd2);
            end
        end
        check("dflt_count_final", 32'(count), 32'd5);
        check("sat_count_final", 32'(count2), 32'd3);

        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_count_kept", 32'(count), 32'd5);
        check("stop_done", 32'(done), 32'd0);

        // 0101 without overlap; start alongside cfg_valid is ignored
        start = 1'b1;
        configure(8'b0101, 4'd4, 1'b0, 10'd0);
        start = 1'b0;
        check("cfgstart_busy", 32'(busy), 32'd0);
        check("cfgstart_err", 32'(cfg_err), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        stream[5:0] = 6'b010101;
        exp_ys[5:0] = 6'b000100;
        for (int i = 5; i >= 0; i--)
            send(stream[i], exp_ys[i], $sformatf("novl_y_bit%0d", 6 - i));
        check("novl_count", 32'(count), 32'd1);

        // Target 2: finish on the second match and ignore later bits
        stop = 1'b1; tick(); stop = 1'b0;
        configure(8'b010, 4'd3, 1'b1, 10'd2);
        start = 1'b1; tick(); start = 1'b0;
        stream[5:0] = 6'b010010;
        exp_ys[5:0] = 6'b001001;
        for (int i = 5; i >= 0; i--)
            send(stream[i], exp_ys[i], $sformatf("tgt_y_bit%0d", 6 - i));
        check("tgt_done", 32'(done), 32'd1);
        check("tgt_busy", 32'(busy), 32'd0);
        check("tgt_count", 32'(count), 32'd2);
        send(1'b0, 1'b0, "tgt_after_y0");
        send(1'b1, 1'b0, "tgt_after_y1");
        send(1'b0, 1'b0, "tgt_after_y2");
        check("tgt_count_hold", 32'(count), 32'd2);
        check("tgt_done_hold", 32'(done), 32'd1);
        check("done_cfg_ready", 32'(cfg_ready), 32'd1);

        // Rejected configurations: len 0 and len 9 in DONE, any cfg while ARMED
        configure(8'hff, 4'd0, 1'b0, 10'd0);
        check("err_len0", 32'(cfg_err), 32'd1);
        tick();
        check("err_len0_clear", 32'(cfg_err), 32'd0);
        configure(8'hff, 4'd9, 1'b0, 10'd0);
        check("err_len9", 32'(cfg_err), 32'd1);
        tick();
        x = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("err_rearm_busy", 32'(busy), 32'd1);
        configure(8'hff, 4'd2, 1'b0, 10'd0);
        check("err_armed", 32'(cfg_err), 32'd1);
        tick();
        check("err_armed_clear", 32'(cfg_err), 32'd0);
        send(1'b1, 1'b0, "cfgkeep_y1");
        send(1'b0, 1'b1, "cfgkeep_y2");
        check("cfgkeep_count", 32'(count), 32'd1);
        check("cfgkeep_busy", 32'(busy), 32'd1);

        // Stop in the middle of a partial match
        send(1'b0, 1'b0, "stopmid_y0");
        send(1'b1, 1'b0, "stopmid_y1");
        x = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
        check("stopmid_y_edge", 32'(y), 32'd0);
        check("stopmid_busy", 32'(busy), 32'd0);
        tick();
        check("stopmid_y_after", 32'(y), 32'd0);
        check("stopmid_count", 32'(count), 32'd1);

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        check("startstop_count", 32'(count), 32'd1);

        // Async reset in the middle of a partial match
        start = 1'b1; tick(); start = 1'b0;
        send(1'b0, 1'b0, "rstmid_a");
        send(1'b1, 1'b0, "rstmid_b");
        send(1'b0, 1'b1, "rstmid_c");
        send(1'b0, 1'b0, "rstmid_d");
        send(1'b1, 1'b0, "rstmid_e");
        x = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rstmid_count_async", 32'(count), 32'd0);
        check("rstmid_busy_async", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_y", 32'(y), 32'd0);
        check("rstmid_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rstmid_done", 32'(done), 32'd0);

        // Reset restored the default config with no target
        start = 1'b1; tick(); start = 1'b0;
        send(1'b0, 1'b0, "rstcfg_y1");
        send(1'b1, 1'b0, "rstcfg_y2");
        send(1'b0, 1'b1, "rstcfg_y3");
        send(1'b1, 1'b0, "rstcfg_y4");
        send(1'b0, 1'b1, "rstcfg_y5");
        check("rstcfg_count", 32'(count), 32'd2);
        check("rstcfg_busy", 32'(busy), 32'd1);
        check("rstcfg_done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
